// File: rtl/tick_monitor.sv
// Tick-interval monitor: measures the spacing of a one-cycle tick stream, recovers
// the power-of-two divide exponent, declares lock on a stable rate and flags errors.
module tick_monitor #(
    parameter int unsigned CLK_DIV_SIZE = 3,
    parameter int unsigned LOCK_COUNT   = 4,
    localparam int unsigned PW          = 2 ** CLK_DIV_SIZE
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tick_in,
    input  logic                    clr_err,
    output logic [PW-1:0]           period,
    output logic                    period_valid,
    output logic [CLK_DIV_SIZE-1:0] div_out,
    output logic                    locked,
    output logic                    err
);

    localparam int unsigned MAXP = 2 ** (PW - 1);
    localparam int unsigned MW   = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_nx;
    logic [PW-1:0]           cnt;
    logic [PW-1:0]           cnt_nx;
    logic [PW-1:0]           cand;
    logic [PW-1:0]           cand_nx;
    logic [MW-1:0]           match;
    logic [MW-1:0]           match_nx;
    logic [MW-1:0]           match_meas;
    logic [PW-1:0]           period_nx;
    logic                    period_valid_nx;
    logic [CLK_DIV_SIZE-1:0] div_nx;
    logic                    locked_nx;
    logic                    err_nx;
    logic                    err_set;
    logic [PW-1:0]           m;
    logic                    m_legal;
    logic                    m_same;
    logic                    timeout;
    logic [CLK_DIV_SIZE-1:0] m_log;

    // Measurement decode shared by all states
    always_comb begin
        m       = cnt + PW'(1);
        m_legal = (m != '0) && ((m & (m - PW'(1))) == '0) && (m <= PW'(MAXP));
        m_same  = (m == cand);
        timeout = (cnt == PW'(MAXP));
        m_log   = '0;
        for (int unsigned i = 0; i < PW; i++) begin
            if (m[CLK_DIV_SIZE'(i)]) begin
                m_log = CLK_DIV_SIZE'(i);
            end
        end
        if (!m_legal) begin
            match_meas = '0;
        end else if (m_same) begin
            match_meas = match + MW'(1);
        end else begin
            match_meas = MW'(1);
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (tick_in) state_nx = MEASURE;
            end
            MEASURE: begin
                if (tick_in) begin
                    if (match_meas == MW'(LOCK_COUNT)) state_nx = LOCKED;
                end else if (timeout) begin
                    state_nx = IDLE;
                end
            end
            LOCKED: begin
                if (tick_in) begin
                    if (!m_same) state_nx = MEASURE;
                end else if (timeout) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Datapath and output next values
    always_comb begin
        cnt_nx          = cnt;
        cand_nx         = cand;
        match_nx        = match;
        period_nx       = period;
        period_valid_nx = 1'b0;
        div_nx          = div_out;
        locked_nx       = locked;
        err_set         = 1'b0;
        if (state == IDLE) begin
            if (tick_in) cnt_nx = '0;
        end else if (tick_in) begin
            period_nx       = m;
            period_valid_nx = 1'b1;
            cnt_nx          = '0;
            // A repeat of the locked period leaves everything untouched
            if (state == MEASURE || !m_same) begin
                match_nx = match_meas;
                if (m_legal && !m_same) cand_nx = m;
            end
            if (state == LOCKED && !m_same) begin
                err_set   = 1'b1;
                locked_nx = 1'b0;
            end
            if (state == MEASURE && match_meas == MW'(LOCK_COUNT)) begin
                div_nx    = m_log;
                locked_nx = 1'b1;
            end
        end else if (timeout) begin
            err_set   = 1'b1;
            locked_nx = 1'b0;
            match_nx  = '0;
        end else begin
            cnt_nx = cnt + PW'(1);
        end
        // A new error event overrides a simultaneous clear
        if (err_set) begin
            err_nx = 1'b1;
        end else if (clr_err) begin
            err_nx = 1'b0;
        end else begin
            err_nx = err;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt          <= '0;
            cand         <= '0;
            match        <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            div_out      <= '0;
            locked       <= 1'b0;
            err          <= 1'b0;
        end else begin
            cnt          <= cnt_nx;
            cand         <= cand_nx;
            match        <= match_nx;
            period       <= period_nx;
            period_valid <= period_valid_nx;
            div_out      <= div_nx;
            locked       <= locked_nx;
            err          <= err_nx;
        end
    end

endmodule

// File: tb/tb_tick_monitor.sv
// Bench for tick_monitor: per-interval vector tables feed an expectation queue that a
// monitor drains one cycle at a time, plus hand sequences for timeout and async reset.
module tb_tick_monitor;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick_in;
    logic       clr_err;
    logic [7:0] period;
    logic       period_valid;
    logic [2:0] div_out;
    logic       locked;
    logic       err;

    tick_monitor #(.CLK_DIV_SIZE(3), .LOCK_COUNT(4)) dut (
        .clk(clk), .rst(rst), .tick_in(tick_in), .clr_err(clr_err),
        .period(period), .period_valid(period_valid), .div_out(div_out),
        .locked(locked), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       pv;
        logic [7:0] per;
        logic       lk;
        logic [2:0] dv;
        logic       er;
    } exp_t;

    // gap = cycles from previous tick edge to this tick edge; expected values at the tick edge
    typedef struct {
        int unsigned gap;
        logic        clr;
        logic        pv;
        logic [7:0]  per;
        logic        lk;
        logic [2:0]  dv;
        logic        er;
    } row_t;

    exp_t       sbq[$];
    exp_t       got_e;
    row_t       rows[$];
    int         checks = 0;
    int         errors = 0;
    string      scen = "reset";
    logic [7:0] h_per;
    logic       h_lk;
    logic [2:0] h_dv;
    logic       h_er;

    // Pop one expectation per clock, sampled just after the edge
    always @(posedge clk) begin
        #1;
        if (sbq.size() != 0) begin
            got_e = sbq.pop_front();
            checks++;
            if ({period_valid, period, locked, div_out, err} !==
                {got_e.pv, got_e.per, got_e.lk, got_e.dv, got_e.er}) begin
                errors++;
                $display("FAIL %s @%0t: got pv=%0b period=%0d locked=%0b div=%0d err=%0b want pv=%0b period=%0d locked=%0b div=%0d err=%0b",
                         scen, $time, period_valid, period, locked, div_out, err,
                         got_e.pv, got_e.per, got_e.lk, got_e.dv, got_e.er);
            end
        end
    end

    function automatic row_t mk(input int unsigned gap, input logic clr, input logic pv,
                                input logic [7:0] per, input logic lk, input logic [2:0] dv,
                                input logic er);
        row_t r;
        r.gap = gap; r.clr = clr; r.pv = pv; r.per = per; r.lk = lk; r.dv = dv; r.er = er;
        return r;
    endfunction

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic cyc(input logic t, input logic c, input exp_t e);
        @(negedge clk);
        tick_in = t;
        clr_err = c;
        sbq.push_back(e);
    endtask

    task automatic hold_cyc();
        exp_t e;
        e = '{1'b0, h_per, h_lk, h_dv, h_er};
        cyc(1'b0, 1'b0, e);
    endtask

    task automatic apply(input row_t r);
        exp_t e;
        for (int i = 1; i < int'(r.gap); i++) hold_cyc();
        e = '{r.pv, r.per, r.lk, r.dv, r.er};
        cyc(1'b1, r.clr, e);
        h_per = r.per; h_lk = r.lk; h_dv = r.dv; h_er = r.er;
    endtask

    task automatic run_rows();
        for (int i = 0; i < rows.size(); i++) apply(rows[i]);
        rows.delete();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        tick_in = 1'b0;
        clr_err = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check({scen, "_reset_state"}, {4'd0, period_valid, period, locked, div_out, err}, 16'd0);
        h_per = '0; h_lk = 1'b0; h_dv = '0; h_er = 1'b0;
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        tick_in = 1'b0;
        clr_err = 1'b0;
        do_reset();

        // Lock at 4, lose it on a 6, relock at 8, then sticky-flag clear cases
        scen = "period4_relock8";
        rows.push_back(mk(4, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++) rows.push_back(mk(4, 0, 1, 4, 0, 0, 0));
        rows.push_back(mk(4, 0, 1, 4, 1, 2, 0));
        rows.push_back(mk(4, 0, 1, 4, 1, 2, 0));
        rows.push_back(mk(6, 0, 1, 6, 0, 2, 1));
        for (int i = 0; i < 3; i++) rows.push_back(mk(8, 0, 1, 8, 0, 2, 1));
        rows.push_back(mk(8, 0, 1, 8, 1, 3, 1));
        rows.push_back(mk(8, 1, 1, 8, 1, 3, 0));
        rows.push_back(mk(4, 1, 1, 4, 0, 3, 1));
        rows.push_back(mk(4, 0, 1, 4, 0, 3, 1));
        run_rows();

        // Held-high ticks lock at div 0; a 129-cycle interval is illegal
        scen = "back_to_back";
        do_reset();
        rows.push_back(mk(1, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++) rows.push_back(mk(1, 0, 1, 1, 0, 0, 0));
        rows.push_back(mk(1, 0, 1, 1, 1, 0, 0));
        rows.push_back(mk(1, 0, 1, 1, 1, 0, 0));
        rows.push_back(mk(129, 0, 1, 129, 0, 0, 1));
        run_rows();

        // Lock at the longest period, then starve it into a timeout
        scen = "period128_timeout";
        do_reset();
        rows.push_back(mk(128, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++) rows.push_back(mk(128, 0, 1, 128, 0, 0, 0));
        rows.push_back(mk(128, 0, 1, 128, 1, 7, 0));
        run_rows();
        for (int i = 0; i < 128; i++) hold_cyc();
        h_lk = 1'b0;
        h_er = 1'b1;
        hold_cyc();
        for (int i = 0; i < 5; i++) hold_cyc();
        rows.push_back(mk(1, 0, 0, 128, 0, 7, 1));
        rows.push_back(mk(4, 0, 1, 4, 0, 7, 1));
        run_rows();

        // Async reset mid-acquisition, then a full re-acquisition
        scen = "async_reset";
        do_reset();
        rows.push_back(mk(4, 0, 0, 0, 0, 0, 0));
        rows.push_back(mk(4, 0, 1, 4, 0, 0, 0));
        rows.push_back(mk(4, 0, 1, 4, 0, 0, 0));
        run_rows();
        @(posedge clk);
        #2;
        check("pre_rst_outputs", {4'd0, period_valid, period, locked, div_out, err},
              {4'd0, 1'b1, 8'd4, 1'b0, 3'd0, 1'b0});
        rst = 1'b1;
        tick_in = 1'b0;
        #1;
        check("async_rst_outputs", {4'd0, period_valid, period, locked, div_out, err}, 16'd0);
        do_reset();
        rows.push_back(mk(4, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++) rows.push_back(mk(4, 0, 1, 4, 0, 0, 0));
        rows.push_back(mk(4, 0, 1, 4, 1, 2, 0));
        run_rows();

        scen = "drain";
        hold_cyc();
        repeat (3) @(negedge clk);
        check("queue_drained", 16'(sbq.size()), 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tick_monitor.md
# tick_monitor

Receive-side companion to the tick divider. It watches a one-cycle tick stream (for example the divider's tick output, or a tick forwarded from another block on the same clock) and measures the interval between ticks in `clk` cycles. It recovers the power-of-two divide exponent, declares lock after a run of consecutive identical intervals, and flags period errors and tick loss. Verification uses it to self-check divider settings, and the design uses it to gate consumers until the tick rate is stable.

## Interface
- `CLK_DIV_SIZE`, 3: width of the divide exponent. Legal exponents are 0..2^CLK_DIV_SIZE-1.
- `LOCK_COUNT`, 4: number of consecutive identical legal measurements required to lock. Range 1..15.
- Derived constants:
  - PW = 2^CLK_DIV_SIZE, the period counter width.
  - MAXP = 2^(PW-1), the longest legal period (128 at defaults).

- `clk`  in  1  single clock for all state.
- `rst`  in  1  reset, asynchronous and active-high; clears all state immediately.
- `tick_in`  in  1  tick pulse, synchronous to `clk`; each high cycle is one tick.
- `clr_err`  in  1  clears the sticky `err` flag.
- `period`  out  PW  last measured interval in `clk` cycles.
- `period_valid`  out  1  one-cycle pulse when `period` is updated.
- `div_out`  out  CLK_DIV_SIZE  recovered exponent; `period` = 2^`div_out` while locked.
- `locked`  out  1  high while the tick rate is stable.
- `err`  out  1  sticky error flag.

## Operation
**Internal state**
- `cnt` (PW bits): counts cycles since the last tick.
- `cand` (PW bits): candidate period.
- `match`: count of consecutive identical legal measurements.
- State machine: IDLE, MEASURE, LOCKED.

**Reset values**
- State = IDLE.
- `cnt`, `cand`, `match`, `period`, `period_valid`, `div_out`, `locked`, `err` all 0.

**IDLE**
- `cnt` holds its value.
- `tick_in` → `cnt`←0, go to MEASURE. No measurement is taken.

**MEASURE or LOCKED, `tick_in` high**
- Measured value m = `cnt`+1.
- `period`←m, `period_valid`←1, `cnt`←0.
- m is legal when it is a power of two and m ≤ MAXP.

**MEASURE, tick arrives**
- m legal and m == `cand`: `match`←`match`+1.
- m legal and m != `cand`: `cand`←m, `match`←1.
- m illegal: `match`←0.
- If the resulting `match` == LOCK_COUNT: `div_out`←log2(m), `locked`←1, go to LOCKED.
- `err` is never set in this state (acquisition transients are expected).

**LOCKED, tick arrives**
- m == `cand`: no change.
- Otherwise:
  - `err`←1, `locked`←0, go to MEASURE.
  - If m is legal: `cand`←m, `match`←1. If m is illegal: `match`←0.
- `div_out` holds its last locked value after lock is lost.

**No tick**
- MEASURE or LOCKED with `cnt` < MAXP: `cnt`←`cnt`+1.
- MEASURE or LOCKED with `cnt` == MAXP (timeout):
  - `err`←1, `locked`←0, `match`←0, go to IDLE.
  - `cnt` stays at MAXP.

**`err` flag**
- Set by a mismatch in LOCKED or by a timeout.
- Cleared by `clr_err`.
- If a set event and `clr_err` occur in the same cycle, the set wins.

## Timing
- All outputs are registered and update on the `clk` edge that samples the triggering `tick_in` or timeout.
- `period_valid` is high for exactly one cycle per measured tick; it is 0 for the first tick after IDLE.
- Lock latency: `locked` rises on the edge of tick number LOCK_COUNT+1 when every interval is equal.
- Back-to-back ticks (`tick_in` held high) measure m=1, giving `div_out`=0.
- Longest legal interval: a tick when `cnt`==MAXP-1 gives m=MAXP.
- A tick when `cnt`==MAXP gives m=MAXP+1, which is illegal.
- Timeout fires on the (MAXP+1)-th edge after the last tick edge.
- `rst` asserted mid-operation clears all outputs asynchronously, without waiting for a `clk` edge. The first tick after reset is treated as an IDLE tick.

## Test plan
All scenarios use the default parameters.

1. Ticks every 4 cycles → `period_valid` pulses with `period`=4 starting at the 2nd tick; `locked`=1 and `div_out`=2 at the 5th tick; `err`=0 throughout.
2. `tick_in` held high → `period`=1 every cycle; `locked` rises on the 5th tick edge with `div_out`=0.
3. Lock at period 4, then one interval of 6, then ticks every 8:
   - The 6-cycle interval → `err`=1 and `locked`=0 on that tick; `div_out` stays 2.
   - Ticks every 8 → relock with `div_out`=3 after 4 measurements of 8.
4. Lock at period 128 (`div_out`=7), then stop ticks → `err`=1, `locked`=0 and state IDLE exactly 129 cycles after the last tick edge; no further `period_valid`.
5. Sticky flag checks:
   - `clr_err` pulse with no error event → `err`=0 on the next cycle.
   - `clr_err` in the same cycle as a LOCKED mismatch → `err` stays 1.
6. Assert `rst` asynchronously mid-MEASURE with `match`=2 → all outputs read 0 before the next `clk` edge. After release, the first tick produces no `period_valid` and lock needs a full LOCK_COUNT+1 ticks.
